// File: rtl/reg_fifo.sv
// reg_fifo: register-based synchronous FIFO with occupancy count and synchronous flush.
// Optional macro REG_FIFO_TRISTATE_EN: drives out through per-bit tri-state buffers gated by out_en.
`default_nettype none

module reg_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           in,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       out_en,
    output logic [WIDTH-1:0]           out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] head;

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign count   = cnt;

    // A pop frees a slot in the same cycle, so push at full is allowed alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rd_ptr];

`ifdef REG_FIFO_TRISTATE_EN
    for (genvar b = 0; b < WIDTH; b++) begin : g_tri
        assign out[b] = out_en ? head[b] : 1'bz;
    end
`else
    logic unused_out_en;
    assign unused_out_en = out_en;
    assign out           = head;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_fifo.sv
// tb_reg_fifo: directed scoreboard bench for reg_fifo (WIDTH=32, DEPTH=4).
`default_nettype none

module tb_reg_fifo;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] din;
    logic        push;
    logic        pop;
    logic        flush;
    logic        out_en;
    logic [31:0] dout;
    logic        full;
    logic        empty;
    logic [2:0]  count;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    reg_fifo #(.WIDTH(32), .DEPTH(4)) dut (
        .clk    (clk),
        .clr    (clr),
        .in     (din),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .out_en (out_en),
        .out    (dout),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock of stimulus; a pop also queues its expected head (v=0: FIFO expected empty).
    task automatic cycle(input logic pu, input logic po, input logic fl,
                         input logic [31:0] d, input logic ev, input logic [31:0] ed);
        push  = pu;
        pop   = po;
        flush = fl;
        din   = d;
        if (po) exp_q.push_back('{v: ev, d: ed});
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic chk_state(input string name, input int c);
        chk({name, "_count"}, 64'(count), 64'(c));
        chk({name, "_full"},  64'(full),  64'(c == 4));
        chk({name, "_empty"}, 64'(empty), 64'(c == 0));
    endtask

    // Monitor: a pop presents the head at mid-cycle; compare against the scoreboard.
    always @(negedge clk) begin
        if (pop === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=pop required=no_pop");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.v) begin
                    chk("pop_data", 64'(dout), 64'(e.d));
                    chk("pop_not_empty", 64'(empty), 64'(0));
                end else begin
                    chk("pop_on_empty", 64'(empty), 64'(1));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr    = 1'b1;
        din    = '0;
        push   = 1'b0;
        pop    = 1'b0;
        flush  = 1'b0;
        out_en = 1'b1;
        #1;
        chk_state("reset", 0);
        chk("reset_out", 64'(dout), 64'h0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Fill to full, then drain in order
        cycle(1, 0, 0, 32'h11, 0, 0); chk_state("fill1", 1);
        cycle(1, 0, 0, 32'h22, 0, 0); chk_state("fill2", 2);
        cycle(1, 0, 0, 32'h33, 0, 0); chk_state("fill3", 3);
        cycle(1, 0, 0, 32'h44, 0, 0); chk_state("fill4", 4);
        chk("full_head", 64'(dout), 64'h11);
        cycle(0, 1, 0, 0, 1, 32'h11); chk_state("drain1", 3);
        cycle(0, 1, 0, 0, 1, 32'h22); chk_state("drain2", 2);
        cycle(0, 1, 0, 0, 1, 32'h33); chk_state("drain3", 1);
        cycle(0, 1, 0, 0, 1, 32'h44); chk_state("drain4", 0);

        // Push at full ignored; push with pop at full keeps count
        cycle(1, 0, 0, 32'h11, 0, 0);
        cycle(1, 0, 0, 32'h22, 0, 0);
        cycle(1, 0, 0, 32'h33, 0, 0);
        cycle(1, 0, 0, 32'h44, 0, 0);
        cycle(1, 0, 0, 32'h55, 0, 0); chk_state("push_full", 4);
        chk("push_full_head", 64'(dout), 64'h11);
        cycle(1, 1, 0, 32'h66, 1, 32'h11); chk_state("pushpop_full", 4);
        cycle(0, 1, 0, 0, 1, 32'h22);
        cycle(0, 1, 0, 0, 1, 32'h33);
        cycle(0, 1, 0, 0, 1, 32'h44);
        cycle(0, 1, 0, 0, 1, 32'h66); chk_state("drain_66", 0);

        // Pop on empty; push+pop on empty takes the push only
        cycle(0, 1, 0, 0, 0, 0);          chk_state("pop_empty", 0);
        cycle(1, 1, 0, 32'hA5, 0, 0);     chk_state("pushpop_empty", 1);
        chk("bypass_head", 64'(dout), 64'hA5);
        cycle(0, 1, 0, 0, 1, 32'hA5);     chk_state("drain_a5", 0);

        // Pointer wrap over 6 laps
        for (int lap = 0; lap < 6; lap++) begin
            for (int k = 0; k < 4; k++) cycle(1, 0, 0, 32'(lap * 16 + k), 0, 0);
            for (int k = 0; k < 4; k++) cycle(0, 1, 0, 0, 1, 32'(lap * 16 + k));
        end
        chk_state("laps", 0);

        // Flush beats a simultaneous push
        cycle(1, 0, 0, 32'h01, 0, 0);
        cycle(1, 0, 0, 32'h02, 0, 0);
        cycle(1, 0, 0, 32'h03, 0, 0);     chk_state("pre_flush", 3);
        cycle(1, 0, 1, 32'h77, 0, 0);     chk_state("flush", 0);
        cycle(1, 0, 0, 32'h88, 0, 0);     chk_state("post_flush", 1);
        chk("post_flush_head", 64'(dout), 64'h88);
        cycle(0, 1, 0, 0, 1, 32'h88);

        // Asynchronous clear between edges, overriding a push
        cycle(1, 0, 0, 32'h12, 0, 0);
        cycle(1, 0, 0, 32'h34, 0, 0);     chk_state("pre_clr", 2);
        #2;
        clr  = 1'b1;
        push = 1'b1;
        din  = 32'hFF;
        #1;
        chk_state("clr_async", 0);
        chk("clr_out", 64'(dout), 64'h0);
        @(posedge clk);
        #1;
        chk_state("clr_hold", 0);
        push = 1'b0;
        #2;
        clr = 1'b0;
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 32'h99, 0, 0);     chk_state("after_clr", 1);
        chk("after_clr_head", 64'(dout), 64'h99);

        // Output enable
        out_en = 1'b0;
        #1;
`ifdef REG_FIFO_TRISTATE_EN
        chk("oe_off", 64'(dout), {32'h0, {32{1'bz}}});
`else
        chk("oe_off", 64'(dout), 64'h99);
`endif
        out_en = 1'b1;
        #1;
        chk("oe_on", 64'(dout), 64'h99);

        @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_fifo.md
REG_FIFO -- requirements
Module: reg_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning entry count (a power of 2, 2..64).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port clr  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port in  input  WIDTH  write data.
REQ-006 The block SHALL have port push  input  1  write request.
REQ-007 The block SHALL have port pop  input  1  read request.
REQ-008 The block SHALL have port flush  input  1  synchronous empty request.
REQ-009 The block SHALL have port out_en  input  1  output drive enable.
REQ-010 The block SHALL have port out  output  WIDTH  head-of-queue data.
REQ-011 The block SHALL have port full  output  1  DEPTH entries held.
REQ-012 The block SHALL have port empty  output  1  zero entries held.
REQ-013 The block SHALL have port count  output  clog2(DEPTH)+1  occupancy, 0..DEPTH.

Function
REQ-014 Storage SHALL be DEPTH registers of WIDTH bits, with write pointer, read pointer and occupancy counter; pointers SHALL wrap from DEPTH-1 to 0.
REQ-015 The push SHALL be accepted when push=1 and (full=0, or pop is accepted in the same cycle); accepted data SHALL be written at the write pointer on that edge.
REQ-016 The pop SHALL be accepted when pop=1 and empty=0; the read pointer SHALL advance on that edge.
REQ-017 Push while full without an accepted pop SHALL be ignored: no storage, pointer or count change.
REQ-018 Pop while empty SHALL be ignored; simultaneous push and pop while empty SHALL accept the push only (no bypass).
REQ-019 Simultaneous accepted push and pop SHALL leave count unchanged, including at full.
REQ-020 The count SHALL increment on a push-only cycle and decrement on a pop-only cycle, and SHALL never leave the range 0..DEPTH.
REQ-021 The flush=1 SHALL, on the next edge, zero both pointers and count, take priority over push/pop in that cycle, and leave storage contents unchanged.
REQ-022 The full, empty and count outputs SHALL be registered-state decodes with no combinational path from push/pop/flush.
REQ-023 The out output SHALL present the entry at the read pointer combinationally from state; write-to-out latency SHALL be one cycle into an empty queue.
REQ-024 While empty=1, the out value SHALL be don't-care for checking purposes but SHALL not be X after reset.

Reset
REQ-025 The clr=1 SHALL immediately, without a clock, clear all storage registers, pointers and count to 0, giving empty=1, full=0, count=0, out=0 (when driven).
REQ-026 The clr SHALL override push/pop/flush, including mid-operation; the first edge after clr deasserts SHALL be processed normally.

Configuration
REQ-027 With macro REG_FIFO_TRISTATE_EN defined, out SHALL be driven through per-bit tri-state buffers: the data when out_en=1, high-impedance on all bits when out_en=0.
REQ-028 With REG_FIFO_TRISTATE_EN undefined, out SHALL always be driven and out_en SHALL be ignored.

Verification
REQ-029 The bench SHALL cover this scenario: WIDTH=32, DEPTH=4; push 0x11,0x22,0x33,0x44 -> full=1, count=4, out=0x11; pop 4x -> out sequence 0x11,0x22,0x33,0x44, then empty=1.
REQ-030 The bench SHALL cover this scenario: at full, push 0x55 alone -> ignored, count=4; next, push 0x66 with pop -> out was 0x11, count stays 4, drain order 0x22,0x33,0x44,0x66.
REQ-031 The bench SHALL cover this scenario: pop on empty, then push 0xA5 with pop on empty -> count=1, out=0xA5 next cycle.
REQ-032 The bench SHALL cover this scenario: 3 entries, flush with push 0x77 -> count=0, empty=1; next push 0x88 -> out=0x88 (pointer wrap exercised over 6 push/pop laps).
REQ-033 The bench SHALL cover this scenario: assert clr between clock edges with count=2 -> empty=1, count=0, out=0 immediately.
REQ-034 The bench SHALL cover this scenario: with REG_FIFO_TRISTATE_EN defined, out_en=0 -> out all Z; out_en=1 -> head data; without the macro, out_en=0 -> head data.
